// File: rtl/pattern_tx_8.sv
// pattern_tx_8: serialises an 8-bit word onto x, one bit per cycle. Alongside it
// the block predicts the response of a "01" detector that watches x all the time,
// and counts those predicted pulses for each frame.
//
// state | meaning
// IDLE  | ready for a load; x low, x_vld low
// SHIFT | presents bit_idx 0..7 of the captured word on x, one per cycle
// DONE  | one cycle of tx_done, then back to IDLE
module pattern_tx_8 #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] din,
    output logic       ready,
    output logic       x,
    output logic       x_vld,
    output logic       exp_y,
    output logic       tx_done,
    output logic [2:0] edge_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] shift_reg, shift_reg_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic       prev_x;
    logic       hist_ok;
    logic       accept;
    logic       ready_nxt;
    logic       x_nxt;
    logic       x_vld_nxt;
    logic       tx_done_nxt;
    logic       exp_y_nxt;

    // Position i of the frame is din[i] when LSB_FIRST, din[7-i] otherwise.
    function automatic logic pick(input logic [7:0] w, input logic [2:0] i);
        if (LSB_FIRST != 0) begin
            return w[i];
        end
        return w[3'd7 - i];
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        shift_reg_nxt = shift_reg;
        bit_idx_nxt   = bit_idx;
        accept        = 1'b0;
        ready_nxt     = 1'b0;
        x_nxt         = 1'b0;
        x_vld_nxt     = 1'b0;
        tx_done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (load && ready) begin
                    accept        = 1'b1;
                    shift_reg_nxt = din;
                    bit_idx_nxt   = 3'd0;
                    state_nxt     = SHIFT;
                    x_nxt         = pick(din, 3'd0);
                    x_vld_nxt     = 1'b1;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_idx == 3'd7) begin
                    state_nxt   = DONE;
                    bit_idx_nxt = 3'd0;
                    tx_done_nxt = 1'b1;
                end else begin
                    bit_idx_nxt = bit_idx + 3'd1;
                    x_nxt       = pick(shift_reg, bit_idx + 3'd1);
                    x_vld_nxt   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase
        // Next cycle's prev_x is today's x, and history is valid after any edge.
        exp_y_nxt = x_nxt & ~x;
    end

    // Datapath, history and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= 8'h00;
            bit_idx   <= 3'd0;
            ready     <= 1'b1;
            x         <= 1'b0;
            x_vld     <= 1'b0;
            tx_done   <= 1'b0;
            exp_y     <= 1'b0;
            prev_x    <= 1'b0;
            hist_ok   <= 1'b0;
            edge_cnt  <= 3'd0;
        end else begin
            shift_reg <= shift_reg_nxt;
            bit_idx   <= bit_idx_nxt;
            ready     <= ready_nxt;
            x         <= x_nxt;
            x_vld     <= x_vld_nxt;
            tx_done   <= tx_done_nxt;
            exp_y     <= exp_y_nxt;
            prev_x    <= x;
            hist_ok   <= 1'b1;
            if (accept) begin
                edge_cnt <= 3'd0;
            end else if (exp_y && hist_ok && (edge_cnt < 3'd4)) begin
                edge_cnt <= edge_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_tx_8.sv
// Directed bench for pattern_tx_8: one LSB-first and one MSB-first instance
// share the same stimulus; sel_msb picks which one the checks observe.
module tb_pattern_tx_8;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] din;

    logic       ready_l, x_l, x_vld_l, exp_y_l, tx_done_l;
    logic [2:0] edge_cnt_l;
    logic       ready_m, x_m, x_vld_m, exp_y_m, tx_done_m;
    logic [2:0] edge_cnt_m;

    logic       sel_msb;
    logic       o_ready, o_x, o_x_vld, o_exp_y, o_tx_done;
    logic [2:0] o_edge_cnt;

    int checks = 0;
    int errors = 0;

    pattern_tx_8 #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst(rst), .load(load), .din(din),
        .ready(ready_l), .x(x_l), .x_vld(x_vld_l), .exp_y(exp_y_l),
        .tx_done(tx_done_l), .edge_cnt(edge_cnt_l)
    );

    pattern_tx_8 #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .load(load), .din(din),
        .ready(ready_m), .x(x_m), .x_vld(x_vld_m), .exp_y(exp_y_m),
        .tx_done(tx_done_m), .edge_cnt(edge_cnt_m)
    );

    assign o_ready    = sel_msb ? ready_m    : ready_l;
    assign o_x        = sel_msb ? x_m        : x_l;
    assign o_x_vld    = sel_msb ? x_vld_m    : x_vld_l;
    assign o_exp_y    = sel_msb ? exp_y_m    : exp_y_l;
    assign o_tx_done  = sel_msb ? tx_done_m  : tx_done_l;
    assign o_edge_cnt = sel_msb ? edge_cnt_m : edge_cnt_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE. ex/ey give x and exp_y for bit index 0..7.
    task automatic run_frame(input string nm, input logic [7:0] d, input logic [7:0] ex,
                             input logic [7:0] ey, input logic [2:0] ecnt);
        chk({nm, " ready_before"}, {7'd0, o_ready}, 8'd1);
        load = 1'b1;
        din  = d;
        @(negedge clk);
        load = 1'b0;
        din  = ~d;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s x[%0d]", nm, i), {7'd0, o_x}, {7'd0, ex[i]});
            chk($sformatf("%s exp_y[%0d]", nm, i), {7'd0, o_exp_y}, {7'd0, ey[i]});
            chk($sformatf("%s x_vld[%0d]", nm, i), {7'd0, o_x_vld}, 8'd1);
            chk($sformatf("%s ready[%0d]", nm, i), {7'd0, o_ready}, 8'd0);
            chk($sformatf("%s tx_done[%0d]", nm, i), {7'd0, o_tx_done}, 8'd0);
            @(negedge clk);
        end
        chk({nm, " done_pulse"}, {7'd0, o_tx_done}, 8'd1);
        chk({nm, " done_x"}, {7'd0, o_x}, 8'd0);
        chk({nm, " done_x_vld"}, {7'd0, o_x_vld}, 8'd0);
        chk({nm, " done_ready"}, {7'd0, o_ready}, 8'd0);
        chk({nm, " done_edge_cnt"}, {5'd0, o_edge_cnt}, {5'd0, ecnt});
        @(negedge clk);
        chk({nm, " idle_ready"}, {7'd0, o_ready}, 8'd1);
        chk({nm, " idle_tx_done"}, {7'd0, o_tx_done}, 8'd0);
        chk({nm, " idle_edge_cnt"}, {5'd0, o_edge_cnt}, {5'd0, ecnt});
    endtask

    logic [7:0] acc;
    logic [7:0] dval;

    initial begin
        sel_msb = 1'b0;
        rst  = 1'b0;
        load = 1'b0;
        din  = 8'h00;
        acc  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values, with load requested during reset.
        load = 1'b1;
        din  = 8'hFF;
        @(negedge clk);
        chk("rst ready", {7'd0, o_ready}, 8'd1);
        chk("rst x", {7'd0, o_x}, 8'd0);
        chk("rst x_vld", {7'd0, o_x_vld}, 8'd0);
        chk("rst exp_y", {7'd0, o_exp_y}, 8'd0);
        chk("rst tx_done", {7'd0, o_tx_done}, 8'd0);
        chk("rst edge_cnt", {5'd0, o_edge_cnt}, 8'd0);
        load = 1'b0;

        // Release and load in the very first cycle afterwards.
        rst = 1'b1;
        run_frame("f55", 8'h55, 8'h55, 8'h55, 3'd4);
        run_frame("fFF", 8'hFF, 8'hFF, 8'h01, 3'd1);
        run_frame("f00", 8'h00, 8'h00, 8'h00, 3'd0);
        sel_msb = 1'b1;
        run_frame("f01_msb", 8'h01, 8'h80, 8'h80, 3'd1);
        sel_msb = 1'b0;

        // Load held high with din changing each cycle: accepts 10 cycles apart.
        load = 1'b1;
        for (int k = 0; k < 30; k++) begin
            chk($sformatf("hold ready[%0d]", k), {7'd0, o_ready}, {7'd0, (k % 10) == 0});
            if ((k % 10) >= 1 && (k % 10) <= 8)
                chk($sformatf("hold x[%0d]", k), {7'd0, o_x}, {7'd0, acc[(k % 10) - 1]});
            chk($sformatf("hold tx_done[%0d]", k), {7'd0, o_tx_done}, {7'd0, (k % 10) == 9});
            dval = 8'(k * 37 + 11);
            din = dval;
            if ((k % 10) == 0) acc = dval;
            @(negedge clk);
        end
        load = 1'b0;
        chk("hold end ready", {7'd0, o_ready}, 8'd1);

        // Reset at bit index 4 of an 0xAA frame.
        load = 1'b1;
        din  = 8'hAA;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort pre x_vld", {7'd0, o_x_vld}, 8'd1);
        rst = 1'b0;
        #1;
        chk("abort ready", {7'd0, o_ready}, 8'd1);
        chk("abort x", {7'd0, o_x}, 8'd0);
        chk("abort x_vld", {7'd0, o_x_vld}, 8'd0);
        chk("abort exp_y", {7'd0, o_exp_y}, 8'd0);
        chk("abort tx_done", {7'd0, o_tx_done}, 8'd0);
        chk("abort edge_cnt", {5'd0, o_edge_cnt}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("abort no_done[%0d]", k), {7'd0, o_tx_done}, 8'd0);
            chk($sformatf("abort idle_ready[%0d]", k), {7'd0, o_ready}, 8'd1);
        end
        run_frame("fAA", 8'hAA, 8'hAA, 8'hAA, 3'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
